// File: rtl/input_feed_scheduler.sv
// Input SRAM feed scheduler: broadcasts start, arbitrates PU input
// requests round-robin over one single-port SRAM and tracks job completion.
module input_feed_scheduler #(
    parameter int NUM_PU  = 4,
    parameter int BIN_LEN = 8,
    parameter int PIXELS  = 64,
    parameter int ADDR_W  = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               job_start,
    output logic               busy,
    output logic               job_done,
    output logic               req_overrun,
    output logic [NUM_PU-1:0]  pu_start,
    input  logic [NUM_PU-1:0]  pu_input_req,
    output logic [BIN_LEN-1:0] pu_input_val,
    output logic [NUM_PU-1:0]  pu_input_ready,
    input  logic [NUM_PU-1:0]  pu_done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [BIN_LEN-1:0] mem_rd_data
);

    localparam int IW = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
    localparam int PW = $clog2(PIXELS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FIN
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q [NUM_PU];
    logic [PW-1:0]     ptr_d [NUM_PU];
    logic [NUM_PU-1:0] done_mask_q, done_mask_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     infl_id_q, infl_id_d;
    logic              infl_q, infl_d;
    logic              ovr_q, ovr_d;

    logic [NUM_PU-1:0] infl_onehot;
    logic [NUM_PU-1:0] exhausted;
    logic [NUM_PU-1:0] eligible;
    logic              gnt_vld;
    logic [IW-1:0]     gnt_idx;
    logic [IW:0]       idx;

    // The PU being answered this cycle still holds its request; mask it.
    always_comb begin
        infl_onehot = '0;
        if (infl_q) begin
            infl_onehot[infl_id_q] = 1'b1;
        end
        for (int i = 0; i < NUM_PU; i++) begin
            exhausted[i] = (ptr_q[i] == PW'(PIXELS));
        end
        eligible = '0;
        if (state_q == S_RUN) begin
            eligible = pu_input_req & ~infl_onehot & ~exhausted;
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_PU; k++) begin
            idx = {1'b0, rr_q} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_PU)) begin
                idx = idx - (IW+1)'(NUM_PU);
            end
            if (!gnt_vld && eligible[idx[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        done_mask_d = done_mask_q;
        rr_d        = rr_q;
        ovr_d       = ovr_q;
        infl_d      = gnt_vld;
        infl_id_d   = gnt_idx;
        unique case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                for (int i = 0; i < NUM_PU; i++) begin
                    ptr_d[i] = '0;
                end
                done_mask_d = '0;
                ovr_d       = 1'b0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                done_mask_d = done_mask_q | pu_done;
                if (|(pu_input_req & exhausted & ~infl_onehot)) begin
                    ovr_d = 1'b1;
                end
                if (gnt_vld) begin
                    ptr_d[gnt_idx] = ptr_q[gnt_idx] + PW'(1);
                    if (gnt_idx == IW'(NUM_PU - 1)) begin
                        rr_d = '0;
                    end else begin
                        rr_d = gnt_idx + IW'(1);
                    end
                end
                // Finish only once the last read has been answered.
                if (&done_mask_d && !infl_q && !gnt_vld) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < NUM_PU; i++) begin
                ptr_q[i] <= '0;
            end
            done_mask_q <= '0;
            rr_q        <= '0;
            infl_q      <= 1'b0;
            infl_id_q   <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            done_mask_q <= done_mask_d;
            rr_q        <= rr_d;
            infl_q      <= infl_d;
            infl_id_q   <= infl_id_d;
            ovr_q       <= ovr_d;
        end
    end

    always_comb begin
        busy           = (state_q != S_IDLE);
        job_done       = (state_q == S_FIN);
        pu_start       = {NUM_PU{state_q == S_START}};
        req_overrun    = ovr_q;
        pu_input_ready = infl_onehot;
        pu_input_val   = infl_q ? mem_rd_data : '0;
        mem_rd_en      = gnt_vld;
        mem_rd_addr    = '0;
        if (gnt_vld) begin
            mem_rd_addr = ADDR_W'(gnt_idx) * ADDR_W'(PIXELS)
                        + ADDR_W'(ptr_q[gnt_idx]);
        end
    end

endmodule
